// File: rtl/spi_wrap_bridge_pkg.sv
// Shared definitions for the SPI wrap bridge: command codes, packet layout,
// FSM encodings and the request/response field structs.
package spi_wrap_bridge_pkg;

    localparam logic [1:0] TYPE_NOP    = 2'd0;
    localparam logic [1:0] TYPE_WRITE  = 2'd1;
    localparam logic [1:0] TYPE_READ   = 2'd2;
    localparam logic [1:0] TYPE_UPDATE = 2'd3;

    localparam logic [15:0] STATUS_HEADER = 16'h57A7;
    localparam logic [3:0]  STATUS_SOF    = 4'hF;
    localparam logic [3:0]  STATUS_EOF    = 4'hF;

    // Bit offsets of the command fields inside s_axis_tdata
    localparam int OFS_ADDR_HI  = 16;
    localparam int OFS_TYPE     = 26;
    localparam int OFS_WDATA_HI = 32;
    localparam int OFS_ADDR_LO  = 36;
    localparam int OFS_WDATA_LO = 52;

    localparam logic [2:0] ST_RESET      = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_READBACK   = 3'd2;
    localparam logic [2:0] ST_WAIT_VALID = 3'd3;
    localparam logic [2:0] ST_WAIT_READY = 3'd4;

    typedef struct packed {
        logic [1:0]  ctype;
        logic [21:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  rtype;
        logic [21:0] raddr;
        logic [15:0] rdata;
        logic [3:0]  eof;
    } resp_t;

endpackage

// File: rtl/spi_wrap_resp_pack.sv
// Combinational packer turning a response record into the 64-bit wrapped
// status word; shared with the single-target decoder.
module spi_wrap_resp_pack
    import spi_wrap_bridge_pkg::*;
(
    input  resp_t       resp,
    output logic [63:0] tdata
);

    assign tdata = {resp.rdata[11:0], resp.eof,
                    resp.raddr[11:0], resp.rdata[15:12],
                    STATUS_SOF, resp.rtype, resp.raddr[21:12],
                    STATUS_HEADER};

endmodule

// File: rtl/spi_wrap_bridge.sv
// Multi-channel SPI wrap bridge: decodes single-beat command packets into
// register-bus cycles on NUM_CH targets and returns wrapped read responses.
module spi_wrap_bridge
    import spi_wrap_bridge_pkg::*;
#(
    parameter int         NUM_CH         = 4,
    parameter int         ADR_BITS       = 2,
    parameter int         TIMEOUT        = 255,
    parameter logic [7:0] TUSER_OUT_MASK = 8'h00,
    parameter logic [7:0] TUSER_OUT      = 8'h00,
    parameter logic [3:0] EOF_ERR        = 4'hE
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [63:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [7:0]                s_axis_tuser,
    output logic [63:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [7:0]                m_axis_tuser,
    output logic                      rst_o,
    output logic [15:0]               dat_o,
    input  logic [NUM_CH-1:0][15:0]   dat_i,
    input  logic [NUM_CH-1:0]         dat_valid_i,
    output logic [ADR_BITS-1:0]       adr_o,
    output logic [NUM_CH-1:0]         en_o,
    output logic                      wr_o
);

    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [2:0]          state;
    cmd_t                cmd;
    logic [CH_BITS-1:0]  in_ch;
    logic [CH_BITS-1:0]  cap_ch;
    logic [CH_BITS-1:0]  stb_ch;
    logic                in_ch_ok;
    logic                accept;
    logic                strobe;
    logic                is_rd;
    logic [21:0]         cap_addr;
    logic [1:0]          cap_type;
    logic [7:0]          cap_tuser;
    logic [15:0]         rdata;
    logic                err;
    logic [31:0]         timer;
    logic                timer_exp;
    logic [15:0]         sel_dat;
    logic                sel_vld;
    resp_t               resp;
    logic                unused_bits;

    assign cmd.ctype = s_axis_tdata[OFS_TYPE +: 2];
    assign cmd.addr  = {s_axis_tdata[OFS_ADDR_HI +: 10], s_axis_tdata[OFS_ADDR_LO +: 12]};
    assign cmd.wdata = {s_axis_tdata[OFS_WDATA_HI +: 4], s_axis_tdata[OFS_WDATA_LO +: 12]};

    assign unused_bits = ^{s_axis_tlast, s_axis_tdata[15:0], s_axis_tdata[31:28],
                           s_axis_tdata[51:48]};

    assign in_ch    = cmd.addr[ADR_BITS +: CH_BITS];
    assign in_ch_ok = int'(in_ch) < NUM_CH;
    assign is_rd    = (cmd.ctype == TYPE_READ) || (cmd.ctype == TYPE_UPDATE);

    assign s_axis_tready = (state == ST_IDLE);
    assign accept        = s_axis_tready && s_axis_tvalid;

    // The accept-cycle strobe is decoded straight from the bus; the
    // read-back strobe replays the captured channel.
    assign strobe = (accept && in_ch_ok && cmd.ctype != TYPE_NOP) || (state == ST_READBACK);
    assign stb_ch = (state == ST_IDLE) ? in_ch : cap_ch;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_en
        assign en_o[k] = strobe && (stb_ch == CH_BITS'(k));
    end

    assign wr_o  = accept && (cmd.ctype == TYPE_WRITE || cmd.ctype == TYPE_UPDATE);
    assign dat_o = accept ? cmd.wdata : 16'h0000;
    assign adr_o = (state == ST_IDLE) ? cmd.addr[ADR_BITS-1:0] : cap_addr[ADR_BITS-1:0];
    assign rst_o = (state == ST_RESET);

    always_comb begin
        sel_dat = 16'h0000;
        sel_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cap_ch == CH_BITS'(k)) begin
                sel_dat = dat_i[k];
                sel_vld = dat_valid_i[k];
            end
        end
    end

    assign timer_exp = (TIMEOUT != 0) && (timer == 32'(TIMEOUT - 1));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_RESET;
            cap_addr  <= '0;
            cap_type  <= '0;
            cap_ch    <= '0;
            cap_tuser <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            timer     <= '0;
        end else begin
            case (state)
                ST_RESET: state <= ST_IDLE;
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        cap_addr  <= cmd.addr;
                        cap_type  <= cmd.ctype;
                        cap_ch    <= in_ch;
                        cap_tuser <= (s_axis_tuser & ~TUSER_OUT_MASK) | (TUSER_OUT_MASK & TUSER_OUT);
                        timer     <= '0;
                        if (is_rd) begin
                            if (!in_ch_ok) begin
                                rdata <= '0;
                                err   <= 1'b1;
                                state <= ST_WAIT_READY;
                            end else begin
                                state <= (cmd.ctype == TYPE_READ) ? ST_WAIT_VALID : ST_READBACK;
                            end
                        end
                    end
                end
                ST_READBACK: begin
                    timer <= '0;
                    state <= ST_WAIT_VALID;
                end
                ST_WAIT_VALID: begin
                    timer <= timer + 32'd1;
                    if (sel_vld) begin
                        rdata <= sel_dat;
                        err   <= 1'b0;
                        state <= ST_WAIT_READY;
                    end else if (timer_exp) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        state <= ST_WAIT_READY;
                    end
                end
                ST_WAIT_READY: if (m_axis_tready) state <= ST_IDLE;
                default: state <= ST_RESET;
            endcase
        end
    end

    assign resp.rtype = cap_type;
    assign resp.raddr = cap_addr;
    assign resp.rdata = rdata;
    assign resp.eof   = err ? EOF_ERR : STATUS_EOF;

    spi_wrap_resp_pack u_pack (
        .resp  (resp),
        .tdata (m_axis_tdata)
    );

    assign m_axis_tvalid = (state == ST_WAIT_READY);
    assign m_axis_tlast  = 1'b1;
    assign m_axis_tuser  = cap_tuser;

endmodule

// File: tb/tb_spi_wrap_bridge.sv
// Randomized bench for spi_wrap_bridge, checked cycle by cycle against a
// transaction-level model of the command/response protocol.
module tb_spi_wrap_bridge;

    localparam int         NUM_CH   = 5;
    localparam int         ADR_BITS = 2;
    localparam int         TIMEOUT  = 8;
    localparam logic [7:0] MASK     = 8'hF0;
    localparam logic [7:0] TUOUT    = 8'hA0;
    localparam logic [3:0] EOF_ERR  = 4'hE;

    logic                    aclk = 1'b0;
    logic                    areset = 1'b1;
    logic [63:0]             s_tdata = '0;
    logic                    s_tvalid = 1'b0;
    logic                    s_tready;
    logic                    s_tlast = 1'b1;
    logic [7:0]              s_tuser = '0;
    logic [63:0]             m_tdata;
    logic                    m_tvalid;
    logic                    m_tready = 1'b0;
    logic                    m_tlast;
    logic [7:0]              m_tuser;
    logic                    rst_o;
    logic [15:0]             dat_o;
    logic [NUM_CH-1:0][15:0] dat_i = '0;
    logic [NUM_CH-1:0]       dat_valid = '0;
    logic [ADR_BITS-1:0]     adr_o;
    logic [NUM_CH-1:0]       en_o;
    logic                    wr_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    spi_wrap_bridge #(
        .NUM_CH(NUM_CH), .ADR_BITS(ADR_BITS), .TIMEOUT(TIMEOUT),
        .TUSER_OUT_MASK(MASK), .TUSER_OUT(TUOUT), .EOF_ERR(EOF_ERR)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .rst_o(rst_o), .dat_o(dat_o), .dat_i(dat_i), .dat_valid_i(dat_valid),
        .adr_o(adr_o), .en_o(en_o), .wr_o(wr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_cmd(input logic [1:0] typ, input logic [21:0] a,
                                           input logic [15:0] wd);
        logic [63:0] t;
        t = {$urandom, $urandom};
        t[16 +: 10] = a[21:12];
        t[36 +: 12] = a[11:0];
        t[26 +: 2]  = typ;
        t[32 +: 4]  = wd[15:12];
        t[52 +: 12] = wd[11:0];
        return t;
    endfunction

    function automatic logic [63:0] exp_resp(input logic [1:0] typ, input logic [21:0] a,
                                             input logic [15:0] rd, input bit e);
        logic [3:0] eof;
        eof = e ? EOF_ERR : 4'hF;
        return {rd[11:0], eof, a[11:0], rd[15:12], 4'hF, typ, a[21:12], 16'h57A7};
    endfunction

    task automatic noise_all();
        for (int k = 0; k < NUM_CH; k++) dat_i[k] = 16'($urandom);
        dat_valid = NUM_CH'($urandom);
    endtask

    // vat: WAIT_VALID cycle index at which the addressed channel answers
    task automatic run_txn(input logic [1:0] typ, input logic [21:0] addr, input logic [15:0] wd,
                           input logic [7:0] tu, input int vat, input logic [15:0] rval,
                           input int rdly);
        logic [2:0]        ch;
        bit                chv;
        logic [NUM_CH-1:0] exp_en;
        logic [15:0]       rd;
        bit                err;
        logic [63:0]       er;
        ch = addr[ADR_BITS +: 3];
        chv = (ch < NUM_CH);
        exp_en = (chv && typ != 2'd0) ? (NUM_CH'(1) << ch) : '0;
        rd = '0;
        err = 1'b0;
        s_tdata = mk_cmd(typ, addr, wd);
        s_tuser = tu;
        s_tvalid = 1'b1;
        #1;
        chk("acc_tready", s_tready, 1'b1);
        chk("acc_en", en_o, exp_en);
        chk("acc_wr", wr_o, (typ == 2'd1 || typ == 2'd3));
        chk("acc_adr", adr_o, addr[ADR_BITS-1:0]);
        chk("acc_dat", dat_o, wd);
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tdata = {$urandom, $urandom};
        if (typ == 2'd0 || typ == 2'd1) begin
            #1;
            chk("nr_tvalid", m_tvalid, 1'b0);
            chk("nr_tready", s_tready, 1'b1);
            @(negedge aclk);
            return;
        end
        if (!chv) begin
            err = 1'b1;
        end else begin
            if (typ == 2'd3) begin
                #1;
                chk("rb_en", en_o, NUM_CH'(1) << ch);
                chk("rb_wr", wr_o, 1'b0);
                chk("rb_adr", adr_o, addr[ADR_BITS-1:0]);
                chk("rb_tvalid", m_tvalid, 1'b0);
                @(negedge aclk);
            end
            for (int i = 0; i < TIMEOUT + 4; i++) begin
                for (int k = 0; k < NUM_CH; k++) dat_i[k] = 16'($urandom);
                dat_valid = NUM_CH'($urandom) & ~(NUM_CH'(1) << ch);
                if (i == vat) begin
                    dat_valid[ch] = 1'b1;
                    dat_i[ch] = rval;
                end
                #1;
                chk("wv_tvalid", m_tvalid, 1'b0);
                chk("wv_tready", s_tready, 1'b0);
                chk("wv_en", en_o, '0);
                @(negedge aclk);
                if (i == vat) begin
                    rd = rval;
                    break;
                end
                if (i == TIMEOUT - 1) begin
                    err = 1'b1;
                    break;
                end
            end
        end
        er = exp_resp(typ, addr, rd, err);
        for (int j = 0; j <= rdly; j++) begin
            noise_all();
            m_tready = (j == rdly);
            #1;
            chk("wr_tvalid", m_tvalid, 1'b1);
            chk("wr_tdata", m_tdata, er);
            chk("wr_tuser", m_tuser, (tu & ~MASK) | (MASK & TUOUT));
            chk("wr_tlast", m_tlast, 1'b1);
            chk("wr_stready", s_tready, 1'b0);
            @(negedge aclk);
        end
        m_tready = 1'b0;
        dat_valid = '0;
        #1;
        chk("done_tvalid", m_tvalid, 1'b0);
        chk("done_tready", s_tready, 1'b1);
        @(negedge aclk);
    endtask

    task automatic do_reset(input int n);
        areset = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = mk_cmd(2'd1, 22'h000004, 16'h5555);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            #1;
            chk("rst_rst_o", rst_o, 1'b1);
            chk("rst_tready", s_tready, 1'b0);
            chk("rst_tvalid", m_tvalid, 1'b0);
            chk("rst_en", en_o, '0);
            chk("rst_wr", wr_o, 1'b0);
            chk("rst_tuser", m_tuser, 8'h00);
        end
        areset = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("rst_tail", rst_o, 1'b1);
        @(negedge aclk);
        #1;
        chk("rst_exit_rst_o", rst_o, 1'b0);
        chk("rst_exit_tready", s_tready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        // directed cases
        run_txn(2'd1, 22'h000006, 16'hBEEF, 8'h13, 0, 16'h0, 0);
        run_txn(2'd2, 22'h00000D, 16'h0000, 8'h5C, 3, 16'h1234, 5);
        run_txn(2'd3, 22'h000001, 16'h00AA, 8'hFF, 2, 16'hC3A5, 0);
        run_txn(2'd2, 22'h2ABC09, 16'h0000, 8'h01, 99, 16'hDEAD, 1);
        run_txn(2'd2, 22'h155408, 16'h0000, 8'h02, TIMEOUT - 1, 16'h8001, 2);
        run_txn(2'd2, 22'h000014, 16'h0000, 8'h77, 0, 16'h9999, 1);
        run_txn(2'd3, 22'h3FFFFF, 16'h1111, 8'h88, 0, 16'h9999, 0);
        run_txn(2'd0, 22'h000008, 16'h2222, 8'h44, 0, 16'h0, 0);

        // reset while waiting for read data: response must be dropped
        s_tdata = mk_cmd(2'd2, 22'h00000D, 16'h0000);
        s_tuser = 8'h3C;
        s_tvalid = 1'b1;
        #1;
        chk("mr_acc_en", en_o, 5'b01000);
        @(negedge aclk);
        s_tvalid = 1'b0;
        #1;
        chk("mr_wv_tvalid", m_tvalid, 1'b0);
        @(negedge aclk);
        dat_valid = 5'b01000;
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            #1;
            chk("mr_post_tvalid", m_tvalid, 1'b0);
        end
        dat_valid = '0;
        @(negedge aclk);
        run_txn(2'd2, 22'h00000D, 16'h0000, 8'h3C, 1, 16'h4321, 0);

        for (int n = 0; n < 40; n++) begin
            run_txn(2'($urandom), 22'($urandom), 16'($urandom), 8'($urandom),
                    $urandom_range(0, TIMEOUT + 1), 16'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
